// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up applied at the end.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  alucontrol,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic              ill_q, ill_d, hold_q, hold_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic              busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag_c, b_mag_c;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    div0_d    = div0_q;
    ill_d     = ill_q;
    hold_d    = hold_q;
    prod_d    = prod_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    result_d  = result_q;

    // Signed operands: a for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM
    a_sgn   = (alucontrol[2:0] == 3'd1) || (alucontrol[2:0] == 3'd2) ||
              (alucontrol[2:0] == 3'd4) || (alucontrol[2:0] == 3'd6);
    b_sgn   = (alucontrol[2:0] == 3'd1) || (alucontrol[2:0] == 3'd4) ||
              (alucontrol[2:0] == 3'd6);
    a_neg   = a_sgn & operand_a[XLEN-1];
    b_neg   = b_sgn & operand_b[XLEN-1];
    a_mag_c = a_neg ? (~operand_a + 32'd1) : operand_a;
    b_mag_c = b_neg ? (~operand_b + 32'd1) : operand_b;

    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q};
    div_shift = {rem_q, quot_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};

    prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;
    quot_fix = div0_q ? '1 : (neg_q ? (~quot_q + 32'd1) : quot_q);
    rem_fix  = rneg_q ? (~rem_q + 32'd1) : rem_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = alucontrol[2:0];
          a_mag_d = a_mag_c;
          b_mag_d = b_mag_c;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          div0_d  = (operand_b == '0);
          prod_d  = {32'd0, b_mag_c};
          quot_d  = a_mag_c;
          rem_d   = '0;
          cnt_d   = '0;
          if (alucontrol[4:3] == 2'b10) begin
            state_d = CALC;
            ill_d   = 1'b0;
            hold_d  = 1'b0;
          end else begin
            // Unsupported codes spend two cycles in FINISH before reporting
            state_d = FINISH;
            ill_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      CALC: begin
        prod_d = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
        if (!div_diff[XLEN]) begin
          rem_d  = div_diff[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d  = div_shift[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FINISH;
      end
      FINISH: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          done_d    = 1'b1;
          illegal_d = ill_q;
          ill_d     = 1'b0;
          state_d   = IDLE;
          if (ill_q) begin
            result_d = '0;
          end else begin
            unique case (op_q)
              3'd0:             result_d = prod_fix[XLEN-1:0];
              3'd1, 3'd2, 3'd3: result_d = prod_fix[2*XLEN-1:XLEN];
              3'd4, 3'd5:       result_d = quot_fix;
              default:          result_d = rem_fix;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      ill_q     <= 1'b0;
      hold_q    <= 1'b0;
      prod_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      div0_q    <= div0_d;
      ill_q     <= ill_d;
      hold_q    <= hold_d;
      prod_q    <= prod_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + reference-model bench for muldiv_unit with a result scoreboard.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  alucontrol;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_res[$];
  logic        sb_ill[$];

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alucontrol (alucontrol),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference using 64-bit host arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, optionally poke start while busy, and check at done
  task automatic run_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat, input bit poke);
    int          lat;
    bit          seen;
    logic [31:0] er;
    logic        ei;
    sb_res.push_back(exp_res);
    sb_ill.push_back(exp_ill);
    @(negedge clk);
    start      = 1'b1;
    alucontrol = code;
    operand_a  = a;
    operand_b  = b;
    @(posedge clk);
    #1;
    start      = poke;
    alucontrol = poke ? 5'b10000 : 5'($urandom);
    operand_a  = $urandom;
    operand_b  = $urandom;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    er = sb_res.pop_front();
    ei = sb_ill.pop_front();
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_illegal"}, 64'(illegal), 64'(ei));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check(tag, 64'(n), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n      = 1'b0;
    start      = 1'b0;
    alucontrol = '0;
    operand_a  = '0;
    operand_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", 5'b10000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 1'b0);
    run_op("mulh", 5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, 1'b0);
    run_op("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
    run_op("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("divu0", 5'b10101, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("remu0", 5'b10111, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 33, 1'b0);
    run_op("div0", 5'b10100, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("rem0", 5'b10110, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 1'b0, 33, 1'b0);
    run_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 1'b0);
    run_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 33, 1'b0);
    run_op("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);

    run_op("illegal", 5'b00011, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b1, 2, 1'b1);
    count_dones("illegal_single_done", 40);
    run_op("after_ill", 5'b10000, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 33, 1'b0);

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom);
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) rb = 32'($urandom_range(1, 9));
      run_op("rand", {2'b10, op}, ra, rb, model(op, ra, rb), 1'b0, 33, 1'b0);
    end

    // Reset in the middle of a divide
    @(negedge clk);
    start      = 1'b1;
    alucontrol = 5'b10100;
    operand_a  = 32'd1000;
    operand_b  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones("midrst_no_done", 40);
    run_op("divu_post_rst", 5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
